// File: rtl/bsg_fifo_multi_pkg.sv
// Shared types and helpers for the multi-channel hardened small FIFO.
// Latency: none (declarations only).
// Backpressure: n/a.
package bsg_fifo_multi_pkg;

  // Counter width for per-channel bookkeeping. Pointers are masked to the
  // real pointer width, so their upper bits stay constant zero.
  localparam int cnt_w_lp = 16;
  typedef logic [cnt_w_lp-1:0] cnt_t;

  // Per-channel state: write pointer, issue pointer, held entries, and
  // entries written but not yet issued to the output stage.
  typedef struct packed {
    cnt_t wptr;
    cnt_t rptr;
    cnt_t total;
    cnt_t pend;
  } chan_state_s;

  // Channel-id width; a single channel still needs one bit.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_fifo_multi_chan_tracker.sv
// Per-channel pointer and occupancy tracker for the shared-memory FIFO.
// Latency: counters update on the clock edge after enq/issue/release.
// Backpressure: ready_o drops when the channel holds els_p unreleased entries.
module bsg_fifo_multi_chan_tracker
  import bsg_fifo_multi_pkg::*;
#(
  parameter  int els_p    = 4,
  localparam int ptr_w_lp = $clog2(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                enq_i,
  input  logic                issue_i,
  input  logic                release_i,
  output logic                ready_o,
  output logic                pend_nz_o,
  output logic [ptr_w_lp-1:0] wptr_o,
  output logic [ptr_w_lp-1:0] rptr_o
);

  localparam cnt_t ptr_mask_lp = cnt_t'(els_p - 1);
  localparam cnt_t els_lp      = cnt_t'(els_p);

  chan_state_s r_state;
  chan_state_s w_state_n;

  // Next state: pointers wrap mod els_p; total counts until release, pend until issue
  always_comb begin
    w_state_n = r_state;
    if (enq_i)   w_state_n.wptr = (r_state.wptr + cnt_t'(1)) & ptr_mask_lp;
    if (issue_i) w_state_n.rptr = (r_state.rptr + cnt_t'(1)) & ptr_mask_lp;
    w_state_n.total = r_state.total + cnt_t'(enq_i) - cnt_t'(release_i);
    w_state_n.pend  = r_state.pend  + cnt_t'(enq_i) - cnt_t'(issue_i);
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= '0;
    else            r_state <= w_state_n;
  end

  // Ready comes purely from registered occupancy: no path from enq or release
  assign ready_o   = (r_state.total < els_lp);
  assign pend_nz_o = (r_state.pend != '0);
  assign wptr_o    = ptr_w_lp'(r_state.wptr);
  assign rptr_o    = ptr_w_lp'(r_state.rptr);

endmodule

// File: rtl/bsg_fifo_1r1w_small_hardened_multi.sv
// num_chan_p FIFOs sharing one sync-read memory; tagged enqueue, round-robin tagged dequeue.
// Latency: accept to v_o 2 cycles, 1 cycle with BSG_FIFO_MULTI_BYPASS_EN defined.
// Backpressure: per-channel ready_o from occupancy; output holds until yumi_i.
module bsg_fifo_1r1w_small_hardened_multi
  import bsg_fifo_multi_pkg::*;
#(
  parameter  int width_p    = 8,
  parameter  int els_p      = 4,
  parameter  int num_chan_p = 3,
  localparam int chan_w_lp  = safe_clog2(num_chan_p),
  localparam int ptr_w_lp   = $clog2(els_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  v_i,
  input  logic [chan_w_lp-1:0]  chan_i,
  input  logic [width_p-1:0]    data_i,
  output logic [num_chan_p-1:0] ready_o,
  output logic                  v_o,
  output logic [chan_w_lp-1:0]  chan_o,
  output logic [width_p-1:0]    data_o,
  input  logic                  yumi_i
);

  logic                  r_v_o;
  logic [chan_w_lp-1:0]  r_chan_o;
  logic [chan_w_lp-1:0]  r_prio;
  logic [width_p-1:0]    r_rdata;
  logic [width_p-1:0]    r_mem [els_p*num_chan_p];

  logic [num_chan_p-1:0] w_enq_vec, w_iss_vec, w_rel_vec, w_pend_nz, w_elig;
  logic [ptr_w_lp-1:0]   w_wptr [num_chan_p];
  logic [ptr_w_lp-1:0]   w_rptr [num_chan_p];
  logic [ptr_w_lp-1:0]   w_wr_ptr, w_rd_ptr;
  logic [chan_w_lp-1:0]  w_gnt;
  logic                  w_any, w_gnt_pnz, w_yumi, w_issue, w_enq, w_rd_en;

  // A yumi without valid data is dropped so it cannot corrupt occupancy
  assign w_yumi  = yumi_i & r_v_o;
  assign w_issue = (~r_v_o | w_yumi) & w_any;
  assign w_enq   = |w_enq_vec;
  // Only a granted channel with stored entries reads memory; a bypass grant does not
  assign w_rd_en = w_issue & w_gnt_pnz;

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    assign w_enq_vec[c] = v_i & (chan_i == chan_w_lp'(c)) & ready_o[c];
    assign w_iss_vec[c] = w_issue & (w_gnt == chan_w_lp'(c));
    assign w_rel_vec[c] = w_yumi & (r_chan_o == chan_w_lp'(c));

    bsg_fifo_multi_chan_tracker #(.els_p(els_p)) u_trk (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .enq_i     (w_enq_vec[c]),
      .issue_i   (w_iss_vec[c]),
      .release_i (w_rel_vec[c]),
      .ready_o   (ready_o[c]),
      .pend_nz_o (w_pend_nz[c]),
      .wptr_o    (w_wptr[c]),
      .rptr_o    (w_rptr[c])
    );
  end

`ifdef BSG_FIFO_MULTI_BYPASS_EN
  // An empty channel being enqueued this cycle competes alongside stored entries
  assign w_elig = w_pend_nz | w_enq_vec;
`else
  assign w_elig = w_pend_nz;
`endif

  // Round-robin: first eligible channel at or above r_prio, else wrap to the lowest
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      if (!w_any && w_elig[c] && (chan_w_lp'(c) >= r_prio)) begin
        w_any = 1'b1;
        w_gnt = chan_w_lp'(c);
      end
    end
    for (int c = 0; c < num_chan_p; c++) begin
      if (!w_any && w_elig[c]) begin
        w_any = 1'b1;
        w_gnt = chan_w_lp'(c);
      end
    end
  end

  // Select write pointer of the enqueued channel and read pointer of the granted one
  always_comb begin
    w_wr_ptr  = '0;
    w_rd_ptr  = '0;
    w_gnt_pnz = 1'b0;
    for (int c = 0; c < num_chan_p; c++) begin
      if (w_enq_vec[c]) w_wr_ptr = w_wptr[c];
      if (w_gnt == chan_w_lp'(c)) begin
        w_rd_ptr  = w_rptr[c];
        w_gnt_pnz = w_pend_nz[c];
      end
    end
  end

  // Shared storage: write slot is always a released slot, so no read/write collision
  always_ff @(posedge clk_i) begin
    if (w_enq)   r_mem[{chan_i, w_wr_ptr}] <= data_i;
    if (w_rd_en) r_rdata <= r_mem[{w_gnt, w_rd_ptr}];
  end

  // Output stage tag and arbiter priority; both hold when nothing issues
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v_o    <= 1'b0;
      r_chan_o <= '0;
      r_prio   <= '0;
    end else if (w_issue) begin
      r_v_o    <= 1'b1;
      r_chan_o <= w_gnt;
      r_prio   <= (w_gnt == chan_w_lp'(num_chan_p - 1)) ? '0 : w_gnt + 1'b1;
    end else if (w_yumi) begin
      r_v_o    <= 1'b0;
    end
  end

`ifdef BSG_FIFO_MULTI_BYPASS_EN
  logic               r_byp_sel;
  logic [width_p-1:0] r_byp_dat;

  // Remember whether the entry on the output came from the bypass path
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   r_byp_sel <= 1'b0;
    else if (w_issue) r_byp_sel <= ~w_gnt_pnz;
  end

  // Capture enqueue payload when it skips the memory
  always_ff @(posedge clk_i) begin
    if (w_issue & ~w_gnt_pnz) r_byp_dat <= data_i;
  end

  assign data_o = r_byp_sel ? r_byp_dat : r_rdata;
`else
  assign data_o = r_rdata;
`endif

  assign v_o    = r_v_o;
  assign chan_o = r_chan_o;

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_hardened_multi.sv
// Scoreboard bench for the multi-channel hardened small FIFO (width 8, 4 entries, 3 channels).
// Latency: expectations follow the 2-cycle path, or 1 cycle with BSG_FIFO_MULTI_BYPASS_EN.
// Backpressure: yumi_i driven directly; the monitor pops on every v_o & yumi_i cycle.
module tb_bsg_fifo_1r1w_small_hardened_multi;

`ifdef BSG_FIFO_MULTI_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       v_i    = 1'b0;
  logic       yumi_i = 1'b0;
  logic [1:0] chan_i = 2'd0;
  logic [7:0] data_i = 8'h00;
  logic [2:0] ready_o;
  logic       v_o;
  logic [1:0] chan_o;
  logic [7:0] data_o;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bsg_fifo_1r1w_small_hardened_multi #(
    .width_p    (8),
    .els_p      (4),
    .num_chan_p (3)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .v_i       (v_i),
    .chan_i    (chan_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .chan_o    (chan_o),
    .data_o    (data_o),
    .yumi_i    (yumi_i)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  // Monitor: every accepted output must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && v_o && yumi_i) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected got chan=%0d data=%h required no output", chan_o, data_o);
      end else begin
        mon_e = expq.pop_front();
        if (chan_o !== mon_e.ch || data_o !== mon_e.d) begin
          errors++;
          $display("FAIL mon_data got chan=%0d data=%h required chan=%0d data=%h",
                   chan_o, data_o, mon_e.ch, mon_e.d);
        end
      end
    end
  end

  // One cycle: drive after the rising edge, return at the falling edge for sampling
  task automatic step(input bit v, input logic [1:0] ch, input logic [7:0] d,
                      input bit y, input bit push);
    @(posedge clk);
    #1;
    v_i    = v;
    chan_i = ch;
    data_i = d;
    yumi_i = y;
    if (push) expq.push_back({ch, d});
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    v_i    = 1'b0;
    yumi_i = 1'b0;
    expq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (expq.size() == 0) break;
      step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  // Enqueue into an empty FIFO with yumi held and check when v_o rises
  task automatic lat_test(input logic [1:0] ch, input logic [7:0] d);
    step(1'b1, ch, d, 1'b1, 1'b1);
    chk("lat_cyc0_v_o", v_o, 0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    chk("lat_cyc1_v_o", v_o, BYP);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    chk("lat_cyc2_v_o", v_o, !BYP);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_v_o", v_o, 0);
    chk("rst_ready", ready_o, 3'b111);
    chk("rst_chan_o", chan_o, 0);

    // Single enqueue latency on channel 1
    lat_test(2'd1, 8'hA1);
    wait_drain();

    // Fill channel 0, refuse further enqueues, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 8'(8'h10 + i), 1'b0, 1'b1);
    chk("fill_ready_3", ready_o, 3'b111);
    step(1'b1, 2'd0, 8'hEE, 1'b0, 1'b0);
    chk("fill_ready_full", ready_o, 3'b110);
    step(1'b1, 2'd0, 8'hEF, 1'b0, 1'b0);
    chk("fill_ready_hold", ready_o, 3'b110);
    wait_drain();
    repeat (3) step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    chk("fill_after_v_o", v_o, 0);
    chk("fill_after_ready", ready_o, 3'b111);

    // Enqueue plus yumi on a full channel, then on a non-full channel
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 8'(8'hA0 + i), 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 2'd0, 8'hA4, 1'b1, 1'b0);
    chk("full_enq_yumi_ready", ready_o[0], 0);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("full_release_ready", ready_o[0], 1);
    step(1'b1, 2'd0, 8'hA4, 1'b1, 1'b1);
    chk("same_ch_ready", ready_o[0], 1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("same_ch_total_kept", ready_o[0], 1);
    step(1'b1, 2'd0, 8'hA5, 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("refill_ready", ready_o[0], 0);
    wait_drain();

    // Two entries per channel, then back-to-back round-robin drain
    do_reset();
    step(1'b1, 2'd0, 8'h10, 1'b0, 1'b1);
    step(1'b1, 2'd1, 8'h20, 1'b0, 1'b1);
    step(1'b1, 2'd2, 8'h30, 1'b0, 1'b1);
    step(1'b1, 2'd0, 8'h11, 1'b0, 1'b1);
    step(1'b1, 2'd1, 8'h21, 1'b0, 1'b1);
    step(1'b1, 2'd2, 8'h31, 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
      chk("rr_no_bubble", v_o, 1);
    end
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    chk("rr_done_v_o", v_o, 0);
    chk("rr_queue_empty", expq.size(), 0);

    // Pointer wrap: ten streaming pairs on channel 2
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'd2, 8'(8'h50 + i), 1'b1, 1'b1);
      chk("wrap_ready", ready_o[2], 1);
    end
    wait_drain();

    // Asynchronous reset while v_o is high; in-flight data is discarded
    do_reset();
    step(1'b1, 2'd1, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 8'hC1, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    chk("mid_v_o_before", v_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_v_o_async", v_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_ready_after", ready_o, 3'b111);
    chk("mid_v_o_after", v_o, 0);
    lat_test(2'd2, 8'h77);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
